fp_mul_arbiter: RTL

Shares one combinational IEEE-754 single-precision multiplier (`multiply`: a, b → result) among NREQ requesters. A round-robin arbiter grants one operand pair at a time, holds the operands stable for a configurable number of evaluation cycles, and registers the product. The product is returned with the requester's index over a valid/ready result channel. The block sits between producer engines and the shared multiplier, and is the only block that drives the multiplier inputs.

---
 rtl/fp_mul_pkg.sv | 24 ++
 rtl/fp_mul_arbiter_if.sv | 33 +++
 rtl/multiply.sv | 56 +++++
 rtl/rr_arbiter.sv | 26 ++
 rtl/fp_mul_arbiter.sv | 115 +++++++++++
 5 files changed

// File: rtl/fp_mul_pkg.sv
// rtl/fp_mul_pkg.sv - shared widths, FSM states and result-flag helpers for fp_mul_arbiter
package fp_mul_pkg;
    localparam int FP32_W = 32;
    localparam int EXP_W  = 8;
    localparam int MAN_W  = 23;

    localparam int FLG_NAN  = 2;
    localparam int FLG_INF  = 1;
    localparam int FLG_ZERO = 0;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    // Sign bit is irrelevant to the flags, so only exponent and mantissa are passed in.
    function automatic logic [2:0] fp_flags(input logic [FP32_W-2:0] x);
        logic [EXP_W-1:0] e;
        logic [MAN_W-1:0] m;
        e = x[FP32_W-2 -: EXP_W];
        m = x[MAN_W-1:0];
        fp_flags           = '0;
        fp_flags[FLG_NAN]  = (e == '1) && (m != '0);
        fp_flags[FLG_INF]  = (e == '1) && (m == '0);
        fp_flags[FLG_ZERO] = (e == '0) && (m == '0);
    endfunction
endpackage

// File: rtl/fp_mul_arbiter_if.sv
// rtl/fp_mul_arbiter_if.sv - requester and result channels of fp_mul_arbiter; FP_MUL_ARB_FLAGS_EN adds res_flags
interface fp_mul_arbiter_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*32-1:0] req_a;
    logic [NREQ*32-1:0] req_b;
    logic               res_valid;
    logic               res_ready;
    logic [31:0]        res_data;
    logic [IDW-1:0]     res_id;
`ifdef FP_MUL_ARB_FLAGS_EN
    logic [2:0]         res_flags;
`endif

    modport master (
        output req_valid, req_a, req_b, res_ready,
`ifdef FP_MUL_ARB_FLAGS_EN
        input  res_flags,
`endif
        input  req_ready, res_valid, res_data, res_id
    );

    modport slave (
        input  req_valid, req_a, req_b, res_ready,
`ifdef FP_MUL_ARB_FLAGS_EN
        output res_flags,
`endif
        output req_ready, res_valid, res_data, res_id
    );
endinterface

// File: rtl/multiply.sv
// rtl/multiply.sv - combinational fp32 multiplier, round-to-nearest-even, subnormals flushed to zero
module multiply
    import fp_mul_pkg::*;
(
    input  logic [FP32_W-1:0] a,
    input  logic [FP32_W-1:0] b,
    output logic [FP32_W-1:0] result
);
    logic              sgn, guard, sticky;
    logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [EXP_W-1:0]  ea, eb;
    logic [MAN_W-1:0]  ma, mb, frac;
    logic [MAN_W:0]    frac_r;
    logic [47:0]       prod;
    logic signed [9:0] exp_r;

    always_comb begin
        sgn    = a[31] ^ b[31];
        ea     = a[30:23];
        eb     = b[30:23];
        ma     = a[22:0];
        mb     = b[22:0];
        a_zero = (ea == '0);
        b_zero = (eb == '0);
        a_inf  = (ea == '1) && (ma == '0);
        b_inf  = (eb == '1) && (mb == '0);
        a_nan  = (ea == '1) && (ma != '0);
        b_nan  = (eb == '1) && (mb != '0);
        prod   = 48'({1'b1, ma}) * 48'({1'b1, mb});
        exp_r  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
        if (prod[47]) begin
            frac   = prod[46:24];
            guard  = prod[23];
            sticky = |prod[22:0];
            exp_r  = exp_r + 10'sd1;
        end else begin
            frac   = prod[45:23];
            guard  = prod[22];
            sticky = |prod[21:0];
        end
        frac_r = {1'b0, frac} + {{MAN_W{1'b0}}, guard & (sticky | frac[0])};
        // A rounding carry leaves the stored fraction at zero, only the exponent moves.
        if (frac_r[MAN_W]) exp_r = exp_r + 10'sd1;

        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
            result = 32'h7FC0_0000;
        else if (a_inf || b_inf)
            result = {sgn, 8'hFF, 23'd0};
        else if (a_zero || b_zero || exp_r <= 10'sd0)
            result = {sgn, 31'd0};
        else if (exp_r >= 10'sd255)
            result = {sgn, 8'hFF, 23'd0};
        else
            result = {sgn, exp_r[7:0], frac_r[MAN_W-1:0]};
    end
endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin picker, search starts at ptr and wraps modulo NREQ
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_idx
);
    int idx;

    // Walk from lowest priority to highest so the closest valid request to ptr is written last.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        idx     = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NREQ;
            if (req[idx]) begin
                gnt     = NREQ'(1) << idx;
                gnt_idx = IDW'(idx);
            end
        end
    end
endmodule

// File: rtl/fp_mul_arbiter.sv
// rtl/fp_mul_arbiter.sv - round-robin share of one fp32 multiplier; FP_MUL_ARB_FLAGS_EN adds res_flags
module fp_mul_arbiter
    import fp_mul_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int MUL_CYC = 1
) (
    input logic             clk,
    input logic             rst,
    fp_mul_arbiter_if.slave bus
);
    localparam int CNT_W = 4;

    state_t              state_q, state_d;
    logic [IDW-1:0]      rr_ptr_q, rr_ptr_d, op_id_q, op_id_d, res_id_q, res_id_d, gnt_idx;
    logic [CNT_W-1:0]    cyc_cnt_q, cyc_cnt_d;
    logic [FP32_W-1:0]   op_a_q, op_a_d, op_b_q, op_b_d, res_data_q, res_data_d;
    logic [FP32_W-1:0]   mul_a, mul_b, mul_y;
    logic [NREQ-1:0]     gnt;
`ifdef FP_MUL_ARB_FLAGS_EN
    logic [2:0]          res_flags_q, res_flags_d;
`endif

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req     (bus.req_valid),
        .ptr     (rr_ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // Operand registers only move on IDLE->CALC, making multiply a MUL_CYC multicycle path.
    assign mul_a = op_a_q;
    assign mul_b = op_b_q;

    multiply u_mul (.a(mul_a), .b(mul_b), .result(mul_y));

    assign bus.req_ready = (state_q == IDLE) ? gnt : '0;
    assign bus.res_valid = (state_q == DONE);
    assign bus.res_data  = res_data_q;
    assign bus.res_id    = res_id_q;
`ifdef FP_MUL_ARB_FLAGS_EN
    assign bus.res_flags = res_flags_q;
`endif

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        cyc_cnt_d  = cyc_cnt_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        op_id_d    = op_id_q;
        res_data_d = res_data_q;
        res_id_d   = res_id_q;
`ifdef FP_MUL_ARB_FLAGS_EN
        res_flags_d = res_flags_q;
`endif
        case (state_q)
            IDLE: begin
                if (|gnt) begin
                    op_a_d    = bus.req_a[int'(gnt_idx)*FP32_W +: FP32_W];
                    op_b_d    = bus.req_b[int'(gnt_idx)*FP32_W +: FP32_W];
                    op_id_d   = gnt_idx;
                    rr_ptr_d  = (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;
                    cyc_cnt_d = CNT_W'(MUL_CYC - 1);
                    state_d   = CALC;
                end
            end
            CALC: begin
                if (cyc_cnt_q == '0) begin
                    res_data_d = mul_y;
                    res_id_d   = op_id_q;
`ifdef FP_MUL_ARB_FLAGS_EN
                    res_flags_d = fp_flags(mul_y[FP32_W-2:0]);
`endif
                    state_d    = DONE;
                end else begin
                    cyc_cnt_d = cyc_cnt_q - 1'b1;
                end
            end
            DONE: begin
                if (bus.res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            cyc_cnt_q  <= '0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            op_id_q    <= '0;
            res_data_q <= '0;
            res_id_q   <= '0;
`ifdef FP_MUL_ARB_FLAGS_EN
            res_flags_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            cyc_cnt_q  <= cyc_cnt_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            op_id_q    <= op_id_d;
            res_data_q <= res_data_d;
            res_id_q   <= res_id_d;
`ifdef FP_MUL_ARB_FLAGS_EN
            res_flags_q <= res_flags_d;
`endif
        end
    end
endmodule
